// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset defaults, FSM encoding, PC increment.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } if_state_e;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: clear wins over load, otherwise contents hold.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (en) begin
      valid <= 1'b1;
      inst  <= d_inst;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, one-outstanding req/ack fetch FSM, 1-entry skid buffer, delay-slot redirect.
// Optional macro IF_ALIGN_CHECK_EN: a misaligned PC raises id_adel instead of fetching.
//   state   | meaning
//   S_FETCH | request outstanding (or being launched) at pc
//   S_HOLD  | skid buffer full, no request
//   S_DROP  | flushed request still in flight, its data is discarded
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        id_adel
`endif
);

  if_state_e   state, state_nxt;
  logic [31:0] pc, drop_addr, skid_inst, skid_pc, redir_tgt, next_pc;
  logic [31:0] id_d_inst, id_d_pc;
  logic        req_en, redir_pend, misaligned, adel_load;
  logic        accept, id_free, to_id, to_skid, skid_out, id_load, id_clr;

`ifdef IF_ALIGN_CHECK_EN
  logic adel_q;
  assign misaligned = (pc[1:0] != 2'b00);
  assign adel_load  = (state == S_FETCH) && req_en && misaligned && !adel_q && id_free && !flush_i;
`else
  assign misaligned = 1'b0;
  assign adel_load  = 1'b0;
`endif

  assign accept   = (state == S_FETCH) && inst_req && inst_ack && !flush_i;
  assign id_free  = !id_valid || !stall_i;
  assign to_id    = accept && id_free;
  assign to_skid  = accept && !id_free;
  assign skid_out = (state == S_HOLD) && !stall_i && !flush_i;
  assign id_load  = to_id || skid_out || adel_load;
  assign id_clr   = flush_i || (!id_load && !stall_i);

  assign next_pc = redirect_valid ? redirect_target :
                   redir_pend     ? redir_tgt       : pc_incr(pc);

  always_comb begin
    id_d_inst = inst_rdata;
    id_d_pc   = pc;
    if (skid_out) begin
      id_d_inst = skid_inst;
      id_d_pc   = skid_pc;
    end else if (adel_load) begin
      id_d_inst = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_FETCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (flush_i)      state_nxt = (inst_req && !inst_ack) ? S_DROP : S_FETCH;
        else if (to_skid) state_nxt = S_HOLD;
      end
      S_HOLD:  if (flush_i || !stall_i) state_nxt = S_FETCH;
      S_DROP:  if (inst_ack) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    inst_req  = 1'b0;
    inst_addr = pc;
    case (state)
      S_FETCH: inst_req = req_en && !misaligned;
      S_DROP: begin
        inst_req  = 1'b1;
        inst_addr = drop_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      req_en     <= 1'b0;
      drop_addr  <= '0;
      skid_inst  <= NOP_INST;
      skid_pc    <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else begin
      req_en    <= 1'b1;
      drop_addr <= inst_addr;
      if (to_skid) begin
        skid_inst <= inst_rdata;
        skid_pc   <= pc;
      end
      if (flush_i) begin
        pc         <= flush_target;
        redir_pend <= 1'b0;
      end else if ((state == S_HOLD) && redirect_valid) begin
        // delay slot already sits in the skid buffer, so the target is the very next fetch
        pc <= redirect_target;
      end else begin
        if (accept) pc <= next_pc;
        if (redirect_valid && !accept) begin
          redir_pend <= 1'b1;
          redir_tgt  <= redirect_target;
        end else if (accept) begin
          redir_pend <= 1'b0;
        end
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adel_q  <= 1'b0;
      id_adel <= 1'b0;
    end else begin
      if (flush_i)        adel_q <= 1'b0;
      else if (adel_load) adel_q <= 1'b1;
      if (id_clr)         id_adel <= 1'b0;
      else if (id_load)   id_adel <= adel_load;
    end
  end
`endif

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk    (clk),
    .resetn (resetn),
    .en     (id_load),
    .clr    (id_clr),
    .d_inst (id_d_inst),
    .d_pc   (id_d_pc),
    .valid  (id_valid),
    .inst   (id_inst),
    .pc     (id_pc)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: program-order reference model, random-latency memory, random stall/flush/branch.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_target = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_valid;
  logic [31:0] id_inst, id_pc;
`ifdef IF_ALIGN_CHECK_EN
  logic        id_adel;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata), .stall_i(stall_i), .flush_i(flush_i),
    .flush_target(flush_target), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc)
`ifdef IF_ALIGN_CHECK_EN
    , .id_adel(id_adel)
`endif
  );

  int          n_cmp = 0, n_bad = 0, n_consumed = 0;
  logic [31:0] sb_q[$];
  logic [31:0] addr_log[$];
  bit          slot_next = 1'b0, sb_off = 1'b0;
  logic [31:0] br_tgt = '0, force_br_pc = 32'h1, force_tgt = '0, mon_e;
  int          fixed_lat = 0, mem_lat = 0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // memory: one transaction at a time, latency fixed or random 0..3 extra cycles
  always @(negedge clk) begin
    if (!resetn) begin
      mem_busy = 1'b0;
      inst_ack = 1'b0;
    end else begin
      inst_ack   = 1'b0;
      inst_rdata = $urandom;
      if (inst_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_addr = inst_addr;
          addr_log.push_back(inst_addr);
          mem_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else begin
          check("addr_stable", inst_addr, mem_addr);
        end
        if (mem_lat == 0) begin
          inst_ack   = 1'b1;
          inst_rdata = memword(mem_addr);
          mem_busy   = 1'b0;
        end else begin
          mem_lat--;
        end
      end
    end
  end

  // monitor: an instruction leaves ID when valid, not stalled and not flushed
  always @(negedge clk) begin
    #2;
    if (resetn && !sb_off) begin
      if (id_valid && !stall_i && !flush_i) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got id_pc %h, expected no instruction", id_pc);
        end else begin
          mon_e = sb_q.pop_front();
          check("id_pc", id_pc, mon_e);
          check("id_inst", id_inst, memword(mon_e));
          n_consumed++;
        end
      end
      if (!id_valid) check("nop_when_invalid", id_inst, NOP_INST_DEF);
    end
  end

  // one cycle of stimulus; the model appends the program-order successor of the consumed instruction
  task automatic step(input bit st, input bit fl, input logic [31:0] ft, input int p_br);
    logic [31:0] cur, tgt;
    @(negedge clk);
    #1;
    stall_i        = st;
    flush_i        = fl;
    flush_target   = ft;
    redirect_valid = 1'b0;
    if (fl) begin
      sb_q.delete();
      sb_q.push_back(ft);
      slot_next = 1'b0;
    end else if (id_valid && !st && sb_q.size() != 0) begin
      cur = sb_q[0];
      if (slot_next) begin
        sb_q.push_back(br_tgt);
        slot_next = 1'b0;
      end else if (cur == force_br_pc || int'($urandom_range(0, 99)) < p_br) begin
        tgt = (cur == force_br_pc) ? force_tgt : {16'hBFC0, 4'h0, 10'($urandom), 2'b00};
        br_tgt          = tgt;
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        sb_q.push_back(cur + 32'd4);
        slot_next = 1'b1;
      end else begin
        sb_q.push_back(cur + 32'd4);
      end
    end
  endtask

  task automatic run_random(input int cycles, input int p_st, input int p_fl, input int p_br);
    for (int i = 0; i < cycles; i++) begin
      if (int'($urandom_range(0, 99)) < p_fl)
        step(1'b0, 1'b1, {16'hBFC0, 4'h0, 10'($urandom), 2'b00}, 0);
      else
        step(int'($urandom_range(0, 99)) < p_st, 1'b0, '0, p_br);
    end
  endtask

  task automatic wait_inflight(input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1'b0, 1'b0, '0, 0);
      found = inst_req && !inst_ack && mem_busy && (mem_lat >= 1);
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no in-flight request, expected one within 50 cycles", nm);
    end
  endtask

  initial begin
    int idx, c0, bubbles, l0;
    bit seen;
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, c0, bubbles, l0;
    bit seen;
    // reset values
    repeat (3) @(negedge clk);
    #1;
    check1("rst_inst_req", inst_req, 1'b0);
    check1("rst_id_valid", id_valid, 1'b0);
    check("rst_id_inst", id_inst, NOP_INST_DEF);
    check("rst_id_pc", id_pc, 32'h0);
    sb_q.push_back(RESET_PC_DEF);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check1("first_req", inst_req, 1'b1);
    check("first_addr", inst_addr, 32'hBFC0_0000);

    // ack every cycle, beq at BFC00010 -> BFC00100
    fixed_lat   = 0;
    force_br_pc = 32'hBFC0_0010;
    force_tgt   = 32'hBFC0_0100;
    c0 = n_consumed;
    repeat (20) step(1'b0, 1'b0, '0, 0);
    force_br_pc = 32'h1;
    check1("throughput", (n_consumed - c0) >= 18, 1'b1);
    idx = -1;
    foreach (addr_log[i]) if (idx < 0 && addr_log[i] == 32'hBFC0_0014) idx = i;
    if (idx < 0 || idx + 1 >= addr_log.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL delay_slot_fetch: got no fetch of BFC00014 followed by another, expected BFC00014 then BFC00100");
    end else begin
      check("branch_target_addr", addr_log[idx+1], 32'hBFC0_0100);
    end

    // stall 3 cycles with ack arriving
    step(1'b1, 1'b0, '0, 0);
    check1("stall_valid_held", id_valid, 1'b1);
    step(1'b1, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    check1("hold_no_req", inst_req, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0, 0);

    // 32-bit PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 0);
    repeat (8) step(1'b0, 1'b0, '0, 0);

    // flush while a 3-cycle-latency request is in flight
    fixed_lat = 3;
    wait_inflight("flush_setup");
    l0 = addr_log.size();
    step(1'b0, 1'b1, 32'hBFC0_0380, 0);
    @(posedge clk);
    #1;
    check1("flush_id_valid", id_valid, 1'b0);
    check1("drop_req_held", inst_req, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b0, 1'b0, '0, 0);
      seen = addr_log.size() > l0;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL flush_restart: got no new fetch, expected BFC00380 within 30 cycles");
    end else begin
      check("flush_restart_addr", addr_log[l0], 32'hBFC0_0380);
    end

    // 3-cycle latency: bubbles between instructions
    bubbles = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, '0, 0);
      if (!id_valid) bubbles++;
    end
    check1("latency_bubbles", bubbles > 0, 1'b1);

`ifdef IF_ALIGN_CHECK_EN
    fixed_lat = 0;
    sb_off = 1'b1;
    step(1'b0, 1'b1, 32'hBFC0_0382, 0);
    step(1'b1, 1'b0, '0, 0);
    @(posedge clk);
    #1;
    check1("adel_no_req", inst_req, 1'b0);
    check1("adel_flag", id_adel, 1'b1);
    check1("adel_valid", id_valid, 1'b1);
    check("adel_inst", id_inst, NOP_INST_DEF);
    check("adel_pc", id_pc, 32'hBFC0_0382);
    step(1'b0, 1'b1, 32'hBFC0_0000, 0);
    sb_off = 1'b0;
`endif

    // randomized traffic
    fixed_lat = -1;
    run_random(1500, 25, 3, 15);

    // reset asserted mid-transaction
    fixed_lat = 3;
    wait_inflight("reset_setup");
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check1("midrst_inst_req", inst_req, 1'b0);
    check1("midrst_id_valid", id_valid, 1'b0);
    check("midrst_id_inst", id_inst, NOP_INST_DEF);
    check("midrst_id_pc", id_pc, 32'h0);
    check("midrst_addr", inst_addr, RESET_PC_DEF);
    repeat (2) @(negedge clk);
    #1;
    sb_q.delete();
    sb_q.push_back(RESET_PC_DEF);
    slot_next = 1'b0;
    resetn = 1'b1;
    fixed_lat = -1;
    c0 = n_consumed;
    run_random(300, 20, 2, 15);
    check1("liveness", (n_consumed - c0) > 40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
